argmax_collector: RTL and testbench

ARGMAX_COLLECTOR -- requirements
Module: argmax_collector

---
 rtl/argmax_collector_pkg.sv | 18 +
 rtl/signed_max_cmp.sv | 20 ++
 rtl/argmax_collector.sv | 154 +++++++++++++++
 tb/tb_argmax_collector.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/argmax_collector_pkg.sv
// argmax_collector_pkg
//   Shared definitions for the argmax collector and the dense layer feeding it:
//   FSM state encoding and default frame geometry.
//   Configuration macro: ARGMAX_READBACK_EN (used by argmax_collector, not here).

package argmax_collector_pkg;

    // Default frame geometry; the dense layer reuses these constants.
    localparam int unsigned OutCountDefault = 10;
    localparam int unsigned DataSizeDefault = 16;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StDone    = 2'd2
    } argmax_state_e;

endpackage

// File: rtl/signed_max_cmp.sv
// signed_max_cmp
//   Combinational signed two's-complement comparator.
//   Ports:
//     a_i  : candidate word
//     b_i  : current maximum
//     gt_o : high when a_i is strictly greater than b_i (signed)

module signed_max_cmp #(
    parameter int unsigned DATA_SIZE = 16
) (
    input  logic [DATA_SIZE-1:0] a_i,
    input  logic [DATA_SIZE-1:0] b_i,
    output logic                 gt_o
);

    always_comb begin
        gt_o = ($signed(a_i) > $signed(b_i));
    end

endmodule

// File: rtl/argmax_collector.sv
// argmax_collector
//   Collects OUT_COUNT signed result words per classification frame and reports
//   the index and value of the largest one (ties keep the lowest index).
//   Configuration macro: ARGMAX_READBACK_EN adds a per-frame word store with a
//   registered readback port.
//   Ports:
//     clk      : clock, rising edge
//     rst      : synchronous active-high reset
//     start    : one-cycle pulse arming a new frame (honoured only in idle)
//     inValid  : qualifies dataIn, one cycle per result word
//     dataIn   : signed result word
//     busy     : high while collecting a frame
//     done     : one-cycle pulse after the last word of a frame is accepted
//     classIdx : index of the maximum word, held between frames
//     maxValue : maximum word, held between frames
//     rdAdr    : readback address (ARGMAX_READBACK_EN only)
//     rdData   : registered readback word, one-cycle latency (ARGMAX_READBACK_EN only)

module argmax_collector
    import argmax_collector_pkg::*;
#(
    parameter int unsigned OUT_COUNT = OutCountDefault,
    parameter int unsigned DATA_SIZE = DataSizeDefault,
    localparam int unsigned IdxW     = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 inValid,
    input  logic [DATA_SIZE-1:0] dataIn,
    output logic                 busy,
    output logic                 done,
    output logic [IdxW-1:0]      classIdx,
    output logic [DATA_SIZE-1:0] maxValue
`ifdef ARGMAX_READBACK_EN
    ,
    input  logic [IdxW-1:0]      rdAdr,
    output logic [DATA_SIZE-1:0] rdData
`endif
);

    localparam logic [IdxW-1:0] LastIdx = IdxW'(OUT_COUNT - 1);

    argmax_state_e        state_q, state_d;
    logic [IdxW-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]      class_idx_q, class_idx_d;
    logic [DATA_SIZE-1:0] max_value_q, max_value_d;
    logic                 accept;
    logic                 is_gt;

    signed_max_cmp #(
        .DATA_SIZE (DATA_SIZE)
    ) u_cmp (
        .a_i  (dataIn),
        .b_i  (max_value_q),
        .gt_o (is_gt)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        class_idx_d = class_idx_q;
        max_value_d = max_value_q;
        accept      = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A word arriving with start belongs to no frame and is dropped.
                if (start) begin
                    state_d = StCollect;
                    cnt_d   = '0;
                end
            end
            StCollect: begin
                if (inValid) begin
                    accept = 1'b1;
                    // First word loads unconditionally; later ones need strict win.
                    if ((cnt_q == '0) || is_gt) begin
                        max_value_d = dataIn;
                        class_idx_d = cnt_q;
                    end
                    if (cnt_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            class_idx_q <= '0;
            max_value_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            class_idx_q <= class_idx_d;
            max_value_q <= max_value_d;
        end
    end

    always_comb begin
        busy     = (state_q == StCollect);
        done     = (state_q == StDone);
        classIdx = class_idx_q;
        maxValue = max_value_q;
    end

`ifdef ARGMAX_READBACK_EN
    logic [DATA_SIZE-1:0] mem_q [OUT_COUNT];
    logic [DATA_SIZE-1:0] mem_d [OUT_COUNT];
    logic [DATA_SIZE-1:0] rd_data_q, rd_data_d;

    always_comb begin
        mem_d = mem_q;
        if (accept) begin
            mem_d[cnt_q] = dataIn;
        end
        // Addresses beyond the frame read as zero.
        rd_data_d = '0;
        if (32'(rdAdr) < OUT_COUNT) begin
            rd_data_d = mem_q[rdAdr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(OUT_COUNT); i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rdData = rd_data_q;
`else
    // No word store in this build; accept only drives the argmax registers.
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_argmax_collector.sv
// tb_argmax_collector
//   Directed self-checking bench for argmax_collector (default 10 x 16-bit).

module tb_argmax_collector;

    logic        clk;
    logic        rst;
    logic        start;
    logic        inValid;
    logic [15:0] dataIn;
    logic        busy;
    logic        done;
    logic [3:0]  classIdx;
    logic [15:0] maxValue;
`ifdef ARGMAX_READBACK_EN
    logic [3:0]  rdAdr;
    logic [15:0] rdData;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int n_done  = 0;
    int done_base;

    argmax_collector #(
        .OUT_COUNT (10),
        .DATA_SIZE (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .inValid  (inValid),
        .dataIn   (dataIn),
        .busy     (busy),
        .done     (done),
        .classIdx (classIdx),
        .maxValue (maxValue)
`ifdef ARGMAX_READBACK_EN
        ,
        .rdAdr    (rdAdr),
        .rdData   (rdData)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done) n_done <= n_done + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One word per call, followed by 'gap' idle cycles.
    task automatic send(input logic [15:0] w, input int gap);
        inValid = 1'b1;
        dataIn  = w;
        step();
        inValid = 1'b0;
        dataIn  = 16'h0;
        for (int i = 0; i < gap; i++) step();
    endtask

    logic [15:0] f1 [10];
    logic [15:0] f4 [10];

    initial begin
        f1 = '{16'd3, 16'hFFFB, 16'd9, 16'd2, 16'd9, 16'd0, 16'hFFFF, 16'd4, 16'd8, 16'd1};
        f4 = '{16'd0, 16'd1, 16'hFFFE, 16'd3, 16'd4, 16'hFFFF, 16'd5, 16'd2, 16'd5, 16'd1};
        rst = 1'b1; start = 1'b0; inValid = 1'b0; dataIn = 16'h0;
`ifdef ARGMAX_READBACK_EN
        rdAdr = 4'd0;
`endif
        step(); step();
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_idx", classIdx, 0);
        check("reset_max", maxValue, 0);

        // Words before start are ignored.
        send(16'd100, 1);
        send(16'd200, 0);
        check("pre_busy", busy, 0);
        check("pre_max", maxValue, 0);

        // start with a word in the same cycle: the word is dropped.
        start = 1'b1; inValid = 1'b1; dataIn = 16'h7000;
        step();
        start = 1'b0; inValid = 1'b0;
        check("start_busy", busy, 1);
        for (int i = 0; i < 9; i++) begin
            send(f1[i], i % 3);
            if (i == 4) begin
                start = 1'b1; step(); start = 1'b0;  // mid-frame start ignored
            end
            check($sformatf("f1_busy%0d", i), busy, 1);
            check($sformatf("f1_nodone%0d", i), done, 0);
        end
        // Last word; done is observed in the cycle after acceptance.
        send(f1[9], 0);
        check("f1_done", done, 1);
        check("f1_busy_lo", busy, 0);
        check("f1_idx", classIdx, 2);
        check("f1_max", maxValue, 16'd9);
        // Word and start during DONE are ignored.
        start = 1'b1; inValid = 1'b1; dataIn = 16'h6000;
        step();
        start = 1'b0; inValid = 1'b0;
        check("f1_done_pulse", done, 0);
        check("f1_done_start_busy", busy, 0);
        check("f1_hold_max", maxValue, 16'd9);
        step();
        check("f1_idle_busy", busy, 0);
        check("f1_hold_idx", classIdx, 2);
`ifdef ARGMAX_READBACK_EN
        rdAdr = 4'd4; step();
        check("rb_4", rdData, 16'd9);
        rdAdr = 4'd1; step();
        check("rb_1", rdData, 16'hFFFB);
`endif

        // All -7: signed compare, first word wins.
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 10; i++) send(16'hFFF9, 0);
        check("f2_done", done, 1);
        check("f2_idx", classIdx, 0);
        check("f2_max", maxValue, 16'hFFF9);
        step();

        // Most negative everywhere, most positive last.
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 9; i++) send(16'h8000, 0);
        check("f3_mid_max", maxValue, 16'h8000);
        send(16'h7FFF, 0);
        check("f3_done", done, 1);
        check("f3_idx", classIdx, 9);
        check("f3_max", maxValue, 16'h7FFF);
        step();

        // Reset mid-frame abandons it; rst beats a simultaneous start.
        done_base = n_done;
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 4; i++) send(16'd50 + 16'(i), 0);
        rst = 1'b1; start = 1'b1; inValid = 1'b1; dataIn = 16'd77;
        step();
        rst = 1'b0; start = 1'b0; inValid = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_idx", classIdx, 0);
        check("rst_max", maxValue, 0);
        step(); step();
        check("rst_no_done", n_done - done_base, 0);
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 10; i++) send(f4[i], 1);
        check("f4_idx", classIdx, 6);
        check("f4_max", maxValue, 16'd5);
        check("f4_one_done", n_done - done_base, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
